// File: rtl/raizing_gfx_pkg.sv
// Shared types and constants for the Raizing tile-fetch arbiter.
package raizing_gfx_pkg;

   localparam int NREQ_C      = 4;
   localparam int BURST_LEN_C = 2;
   localparam int TILE_DW_C   = 32;
   localparam int BEAT_DW_C   = TILE_DW_C / BURST_LEN_C;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LO   = 2'd2,
      ST_HI   = 2'd3
   } gfx_state_t;

endpackage

// File: rtl/raizing_rr_pick.sv
// Rotating priority encoder: first pending requester after last_grant wins.
// With prio0_en, requester 0 pre-empts and 1..3 rotate among themselves.
module raizing_rr_pick
   import raizing_gfx_pkg::*;
(
   input  logic [NREQ_C-1:0] pending,
   input  logic [1:0]        last_grant,
   input  logic              prio0_en,
   output logic [1:0]        grant,
   output logic              any
);

   logic [1:0]        cand_idx [NREQ_C];
   logic [NREQ_C-1:0] rr_pending;

   assign rr_pending = prio0_en ? {pending[NREQ_C-1:1], 1'b0} : pending;
   assign any        = |pending;

   generate
      for (genvar gi = 0; gi < NREQ_C; gi++) begin : g_cand
         assign cand_idx[gi] = last_grant + 2'(gi + 1);
      end
   endgenerate

   // Scan from lowest to highest priority so the nearest candidate wins.
   always_comb begin
      grant = 2'd0;
      for (int i = NREQ_C - 1; i >= 0; i--) begin
         if (rr_pending[cand_idx[i]]) grant = cand_idx[i];
      end
      if (prio0_en && pending[0]) grant = 2'd0;
   end

endmodule

// File: rtl/raizing_gfx_arb.sv
// Four-way tile-fetch arbiter with a one-entry cache per requester, fed by
// two-beat SDRAM reads. Define RAIZING_GFX_ARB_PRIO0_EN to give requester 0 priority.
module raizing_gfx_arb
   import raizing_gfx_pkg::*;
#(
   parameter int AW   = 22,
   parameter int NREQ = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [NREQ-1:0]               REQ_CS,
   input  logic [NREQ*AW-1:0]            REQ_ADDR,
   output logic [NREQ-1:0]               REQ_OK,
   output logic [NREQ*TILE_DW_C-1:0]     REQ_DOUT,
   output logic [AW-1:0]                 BA_ADDR,
   output logic                          BA_RD,
   input  logic                          BA_ACK,
   input  logic                          BA_DOK,
   input  logic                          BA_RDY,
   input  logic [BEAT_DW_C-1:0]          DATA_READ
);

`ifdef RAIZING_GFX_ARB_PRIO0_EN
   localparam logic prio0_en = 1'b1;
`else
   localparam logic prio0_en = 1'b0;
`endif

   gfx_state_t            state_reg, state_next;
   logic [AW-1:0]         req_addr [NREQ];
   logic [NREQ-1:0]       pending;
   logic [1:0]            grant_reg, last_grant_reg, pick_grant;
   logic                  pick_any;
   logic [AW-1:0]         addr_reg;
   logic [BEAT_DW_C-1:0]  lo_reg;
   logic                  complete;
   logic [TILE_DW_C-1:0]  fill_data;

   raizing_rr_pick u_pick (
      .pending    (pending),
      .last_grant (last_grant_reg),
      .prio0_en   (prio0_en),
      .grant      (pick_grant),
      .any        (pick_any)
   );

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_entry
         logic [AW-1:0]        tag_reg;
         logic [TILE_DW_C-1:0] data_reg;
         logic                 valid_reg;

         assign req_addr[gi] = REQ_ADDR[gi*AW +: AW];
         // Hit is combinational so an address change drops OK immediately.
         assign REQ_OK[gi]   = REQ_CS[gi] & valid_reg & (tag_reg == req_addr[gi]);
         assign pending[gi]  = REQ_CS[gi] & ~REQ_OK[gi];
         assign REQ_DOUT[gi*TILE_DW_C +: TILE_DW_C] = data_reg;

         always_ff @(posedge CLK) begin
            if (RESET) begin
               tag_reg   <= '0;
               data_reg  <= '0;
               valid_reg <= 1'b0;
            end else if (complete && grant_reg == 2'(gi)) begin
               tag_reg   <= addr_reg;
               data_reg  <= fill_data;
               valid_reg <= 1'b1;
            end
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      complete   = 1'b0;
      fill_data  = {DATA_READ, lo_reg};
      unique case (state_reg)
         ST_IDLE: if (pick_any) state_next = ST_REQ;
         ST_REQ:  if (BA_ACK) state_next = ST_LO;
         ST_LO: begin
            if (BA_DOK) begin
               if (BA_RDY) begin
                  // Short burst: the single beat is the low half.
                  complete   = 1'b1;
                  fill_data  = {{BEAT_DW_C{1'b0}}, DATA_READ};
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (BA_DOK && BA_RDY) begin
               complete   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg      <= ST_IDLE;
         BA_RD          <= 1'b0;
         BA_ADDR        <= '0;
         grant_reg      <= 2'd0;
         last_grant_reg <= 2'd3;
         addr_reg       <= '0;
         lo_reg         <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && pick_any) begin
            grant_reg <= pick_grant;
            addr_reg  <= req_addr[pick_grant];
            BA_ADDR   <= {req_addr[pick_grant][AW-2:0], 1'b0};
            BA_RD     <= 1'b1;
            // Priority-0 grants must not disturb the rotation among 1..3.
            if (!prio0_en || pick_grant != 2'd0) last_grant_reg <= pick_grant;
         end
         if (state_reg == ST_REQ && BA_ACK) BA_RD <= 1'b0;
         if (state_reg == ST_LO && BA_DOK) lo_reg <= DATA_READ;
      end
   end

endmodule
